data_memory: RTL

- Data memory for the MEM stage of the 64-bit RISC-V core.
- Directly upstream of the MemtoReg write-back mux: its ReadData output is that mux's ReadData input.
- Services one load or store at a time with a fixed, parameterised access latency and a Ready completion pulse.
- Implements RV64I load/store sizes, little-endian byte lanes, sign/zero extension and misalignment detection.

---
 rtl/riscv_mem_pkg.sv | 25 ++
 rtl/mem_lane_align.sv | 58 +++++
 rtl/data_memory.sv | 124 ++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared funct3 encodings, FSM states and access-size decode for the MEM-stage data memory.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} memState_e;

  function automatic logic [3:0] sizeBytes(input logic [2:0] funct3);
    logic [3:0] size;
    case (funct3[1:0])
      2'b00:   size = 4'd1;
      2'b01:   size = 4'd2;
      2'b10:   size = 4'd4;
      default: size = 4'd8;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store byte enables/shifted data, load extraction with extension,
// and misaligned/illegal classification of a latched request.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic        isLoad,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [2:0]  byteOffset,
  input  logic [63:0] writeData,
  input  logic [63:0] wordData,
  output logic [7:0]  byteEnable,
  output logic [63:0] laneWriteData,
  output logic [63:0] loadData,
  output logic        misaligned,
  output logic        illegal
);

  logic [3:0]  size;
  logic [5:0]  bitOffset;
  logic [7:0]  sizeMask;
  logic [63:0] laneData;

  assign size          = sizeBytes(funct3);
  assign bitOffset     = {byteOffset, 3'b000};
  assign byteEnable    = sizeMask << byteOffset;
  assign laneWriteData = writeData << bitOffset;
  assign laneData      = wordData >> bitOffset;
  assign misaligned    = |({1'b0, byteOffset} & (size - 4'd1));
  assign illegal       = (isLoad && isStore) ||
                         (isLoad && funct3 == 3'b111) ||
                         (isStore && funct3[2]);

  always_comb begin
    sizeMask = 8'hFF;
    case (funct3[1:0])
      2'b00:   sizeMask = 8'h01;
      2'b01:   sizeMask = 8'h03;
      2'b10:   sizeMask = 8'h0F;
      default: sizeMask = 8'hFF;
    endcase
  end

  always_comb begin
    loadData = laneData;
    case (funct3)
      F3_B:    loadData = {{56{laneData[7]}}, laneData[7:0]};
      F3_H:    loadData = {{48{laneData[15]}}, laneData[15:0]};
      F3_W:    loadData = {{32{laneData[31]}}, laneData[31:0]};
      F3_D:    loadData = laneData;
      F3_BU:   loadData = {56'd0, laneData[7:0]};
      F3_HU:   loadData = {48'd0, laneData[15:0]};
      F3_WU:   loadData = {32'd0, laneData[31:0]};
      default: loadData = laneData;
    endcase
  end

endmodule

// File: rtl/data_memory.sv
// MEM-stage data memory: one request at a time, Ready pulses LATENCY cycles after acceptance;
// requests arriving while Busy are ignored since the accepted request is latched.
module data_memory
  import riscv_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [63:0] Address,
  input  logic [63:0] WriteData,
  output logic [63:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        Misaligned,
  output logic        Error
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  memState_e        state, nextState;
  logic [CNT_W-1:0] count;
  logic             reqRead, reqWrite;
  logic [2:0]       reqFunct3;
  logic [IDX_W+2:0] reqAddr;
  logic [63:0]      reqData;
  logic [63:0]      heldData;
  logic [63:0]      mem [DEPTH_WORDS];

  logic [7:0]       byteEnable;
  logic [63:0]      laneWriteData, loadData;
  logic             laneMisaligned, laneIllegal;
  logic             doStore, doLoad;
  logic             unusedAddrHi;

  // Upper address bits alias by design.
  assign unusedAddrHi = ^Address[63:IDX_W+3];

  mem_lane_align u_lane (
    .isLoad        (reqRead),
    .isStore       (reqWrite),
    .funct3        (reqFunct3),
    .byteOffset    (reqAddr[2:0]),
    .writeData     (reqData),
    .wordData      (mem[reqAddr[IDX_W+2:3]]),
    .byteEnable    (byteEnable),
    .laneWriteData (laneWriteData),
    .loadData      (loadData),
    .misaligned    (laneMisaligned),
    .illegal       (laneIllegal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '0;
      reqRead   <= 1'b0;
      reqWrite  <= 1'b0;
      reqFunct3 <= '0;
      reqAddr   <= '0;
      reqData   <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && (MemRead || MemWrite)) begin
        reqRead   <= MemRead;
        reqWrite  <= MemWrite;
        reqFunct3 <= Funct3;
        reqAddr   <= Address[IDX_W+2:0];
        reqData   <= WriteData;
        count     <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  always_comb begin
    nextState  = state;
    Ready      = 1'b0;
    Busy       = 1'b0;
    Misaligned = 1'b0;
    Error      = 1'b0;
    doStore    = 1'b0;
    doLoad     = 1'b0;
    case (state)
      IDLE: if (MemRead || MemWrite) nextState = (LATENCY == 1) ? DONE : WAIT;
      WAIT: begin
        Busy = 1'b1;
        if (count <= CNT_W'(1)) nextState = DONE;
      end
      DONE: begin
        Ready      = 1'b1;
        Misaligned = laneMisaligned;
        Error      = laneIllegal;
        // A reset landing on the completion edge suppresses the side effects.
        doStore    = reqWrite && !laneIllegal && !laneMisaligned && !reset;
        doLoad     = reqRead && !laneIllegal && !laneMisaligned && !reset;
        nextState  = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) heldData <= '0;
    else if (doLoad) heldData <= loadData;
  end

  assign ReadData = doLoad ? loadData : heldData;

  always_ff @(posedge clk) begin
    if (doStore) begin
      for (int b = 0; b < 8; b++) begin
        if (byteEnable[b]) mem[reqAddr[IDX_W+2:3]][b*8 +: 8] <= laneWriteData[b*8 +: 8];
      end
    end
  end

endmodule
